alu_issue_ctrl: RTL
===================

// Module: alu_issue_ctrl
// PURPOSE
//  Initiator side of the ALU operand/result interface. Accepts ALU commands on a
//  valid/ready port and drives opcode/operands to a combinational or pipelined ALU.
//  Captures the result after a fixed latency and returns it with a tag on a
//  valid/ready response port. Sits between the instruction sequencer and the ALU.
// PARAMETERS
//  N       32  operand/result width
//  TAG_W   4   command tag width
//  ALU_LAT 0   ALU result latency in cycles after operands are stable (0 = combinational)
// PORTS
//  clk          in   1      clock; all state changes on rising edge
//  rst_n        in   1      asynchronous active-low reset
//  cmd_valid    in   1      command valid
//  cmd_ready    out  1      command ready
//  cmd_opcode   in   4      0 ADD, 1 LESS, 2 EQ, 3 OR, 4 AND, 5 NOT, 6 MUL, 7 SHR, 8 SHL
//  cmd_a        in   N      operand A
//  cmd_b        in   N      operand B
//  cmd_tag      in   TAG_W  tag, echoed on response
//  cmd_fwd      in   1      use last result as A (port exists only with ALU_ISSUE_FWD_EN)
//  alu_opcode   out  4      opcode to ALU
//  alu_op_a     out  N      operand A to ALU
//  alu_op_b     out  N      operand B to ALU
//  alu_result   in   N      ALU result
//  rsp_valid    out  1      response valid
//  rsp_ready    in   1      response ready
//  rsp_result   out  N      captured result (0 on error)
//  rsp_tag      out  TAG_W  tag of completed command
//  rsp_err      out  1      illegal opcode (9..15)
//  busy         out  1      high in any state other than IDLE
//  err_cnt      out  16     count of illegal commands, saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset: state IDLE; every output 0 except cmd_ready=1; err_cnt and last-result reg 0.
//  - FSM: IDLE -> WAIT (legal opcode) or RESP (illegal) on cmd_valid&&cmd_ready;
//    WAIT -> RESP after ALU_LAT+1 cycles; RESP -> IDLE on rsp_valid&&rsp_ready.
//  - cmd_ready = (state==IDLE), combinational from state only; no cmd->ready path.
//  - Accept edge: opcode/operands/tag registered; alu_* driven from those registers,
//    held stable through WAIT and RESP and after, until the next legal accept.
//  - WAIT: down-counter loaded with ALU_LAT; alu_result sampled on the edge where the
//    counter is 0 -> rsp_result, rsp_valid=1. Latency: accept edge k -> rsp_valid high
//    after edge k+ALU_LAT+1.
//  - Illegal opcode: no ALU issue (alu_* unchanged); RESP after the accept edge with
//    rsp_err=1, rsp_result=0; err_cnt += 1 (saturating).
//  - RESP: rsp_valid, rsp_result, rsp_tag, rsp_err held stable until accepted; the
//    handshake edge clears rsp_valid; cmd_ready rises next cycle (no same-cycle re-accept).
//    Peak throughput: one command per ALU_LAT+3 cycles.
//  - Width: result passed through unmodified at width N; no truncation or extension.
//  - Reset asserted mid-WAIT/RESP: immediate return to reset values; command dropped,
//    no response produced.
// CONFIGURATION
//  ALU_ISSUE_FWD_EN defined: cmd_fwd port present. At accept with cmd_fwd=1, A operand =
//    last-result reg, cmd_a ignored. Last-result reg updates on every non-error capture;
//    error responses leave it unchanged.
//  ALU_ISSUE_FWD_EN undefined: no cmd_fwd port, no last-result reg; A operand = cmd_a always.
// TESTING  (bench contains a behavioural ALU model with configurable ALU_LAT)
//  1. ALU_LAT=0, ADD a=5 b=7 tag=3, rsp_ready=1 -> rsp_valid 1 cycle after accept,
//     rsp_result=12, rsp_tag=3, rsp_err=0; cmd_ready high again 2 cycles after accept.
//  2. opcode=9 tag=1 -> rsp_err=1, rsp_result=0, alu_* unchanged, err_cnt=1.
//  3. ALU_LAT=2, LESS a=3 b=32'hFFFFFFFF, rsp_ready low 5 cycles -> rsp_valid 3 cycles
//     after accept, result=1 held stable, cmd_ready=0 throughout, release -> IDLE.
//  4. Back-to-back SHL a=32'h80000001 then NOT a=0, cmd_valid held -> results 32'h2,
//     32'hFFFFFFFF, in order, tags correct, second accept only after first response.
//  5. ALU_LAT=3, assert rst_n=0 during WAIT -> all outputs at reset values immediately,
//     no rsp_valid afterwards, next command completes normally.
//  6. ALU_ISSUE_FWD_EN: ADD 1+1, then MUL cmd_fwd=1 cmd_a=99 b=5 -> results 2, 10;
//     after an illegal command, cmd_fwd ADD b=0 -> 10.

Source files
------------

// File: rtl/alu_issue_if.sv
// alu_issue_if: command, ALU operand/result and response bundle for alu_issue_ctrl
// The cmd_fwd signal exists only when ALU_ISSUE_FWD_EN is defined.
interface alu_issue_if #(parameter int N = 32, parameter int TAG_W = 4);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_opcode;
  logic [N-1:0]     cmd_a;
  logic [N-1:0]     cmd_b;
  logic [TAG_W-1:0] cmd_tag;
`ifdef ALU_ISSUE_FWD_EN
  logic             cmd_fwd;
`endif
  logic [3:0]       alu_opcode;
  logic [N-1:0]     alu_op_a;
  logic [N-1:0]     alu_op_b;
  logic [N-1:0]     alu_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [N-1:0]     rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  modport master (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_tag,
`ifdef ALU_ISSUE_FWD_EN
    input  cmd_fwd,
`endif
    input  alu_result, rsp_ready,
    output cmd_ready, alu_opcode, alu_op_a, alu_op_b, rsp_valid, rsp_result, rsp_tag, rsp_err
  );
  modport slave (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_tag,
`ifdef ALU_ISSUE_FWD_EN
    output cmd_fwd,
`endif
    output alu_result, rsp_ready,
    input  cmd_ready, alu_opcode, alu_op_a, alu_op_b, rsp_valid, rsp_result, rsp_tag, rsp_err
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues commands to a fixed-latency ALU and returns tagged results
// Define ALU_ISSUE_FWD_EN to enable forwarding of the last result as operand A.
module alu_issue_ctrl #(
  parameter int N       = 32,
  parameter int TAG_W   = 4,
  parameter int ALU_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.master bus,
  output logic        busy,
  output logic [15:0] err_cnt
);
  localparam int CW = ALU_LAT > 0 ? $clog2(ALU_LAT + 1) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [3:0]       opc_q;
  logic [N-1:0]     a_q, b_q, res_q, a_in;
  logic [TAG_W-1:0] tag_q;
  logic             err_q, acc, legal;
`ifdef ALU_ISSUE_FWD_EN
  logic [N-1:0]     last_q;
  assign a_in = bus.cmd_fwd ? last_q : bus.cmd_a;
`else
  assign a_in = bus.cmd_a;
`endif
  assign acc   = bus.cmd_valid && state == IDLE;
  assign legal = bus.cmd_opcode < 4'd9;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (acc ? (legal ? WAIT : RESP) : IDLE) :
               state == WAIT ? (cnt == '0 ? RESP : WAIT) :
               (bus.rsp_ready ? IDLE : RESP);
  always_comb begin
    bus.cmd_ready = state == IDLE;
    bus.rsp_valid = state == RESP;
    busy          = state != IDLE;
  end
  assign bus.alu_opcode = opc_q;
  assign bus.alu_op_a   = a_q;
  assign bus.alu_op_b   = b_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_tag    = tag_q;
  assign bus.rsp_err    = err_q;
  // Operands only move on a legal accept so the ALU inputs stay stable otherwise.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt     <= '0;
      opc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
      err_cnt <= '0;
`ifdef ALU_ISSUE_FWD_EN
      last_q  <= '0;
`endif
    end else begin
      if (acc) begin
        tag_q <= bus.cmd_tag;
        err_q <= !legal;
        cnt   <= CW'(ALU_LAT);
        if (legal) begin
          opc_q <= bus.cmd_opcode;
          a_q   <= a_in;
          b_q   <= bus.cmd_b;
        end else begin
          res_q <= '0;
          if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
      end
      if (state == WAIT) begin
        if (cnt == '0) begin
          res_q  <= bus.alu_result;
`ifdef ALU_ISSUE_FWD_EN
          last_q <= bus.alu_result;
`endif
        end else cnt <= cnt - CW'(1);
      end
    end
endmodule
